// File: rtl/phys_reg_desc_table.sv
// ---------------------------------------------------------------------------
// phys_reg_desc_table
//
// Purpose:
//   Table of per-physical-register descriptors. It has NWR write ports that
//   are qualified by the commit stage and NRD combinational read ports. A
//   clear sweep zeroes the whole table, NWR entries per cycle.
//
// Ports:
//   clk           - single clock; all state updates on the rising edge
//   reset         - asynchronous, active-low reset (zeroes table, FSM to IDLE)
//   en            - global write enable
//   commitAllow   - write qualifier from the commit stage
//   writeEn       - per-port write enable, bit k = port k
//   writeSelect   - packed write indices, port k at [k*IDX_W +: IDX_W]
//   writeData     - packed write descriptors, port k at [k*DESC_W +: DESC_W]
//   readSelect    - packed read indices, port j at [j*IDX_W +: IDX_W]
//   readData      - packed read descriptors, port j at [j*DESC_W +: DESC_W]
//   clearReq      - level-sampled request to zero the whole table
//   clearBusy     - high while the clear sweep is in progress (registered)
//   writeConflict - registered pulse: the previous cycle had two accepted
//                   writes to the same index
//
// Configuration:
//   PHYS_REG_DESC_BYPASS_EN - when defined, a read returns the data of the
//   winning accepted write to the same index in the same cycle. When it is
//   not defined, a read returns only the stored entry.
// ---------------------------------------------------------------------------
module phys_reg_desc_table #(
    parameter int NREGS  = 64,
    parameter int IDX_W  = 6,
    parameter int DESC_W = 3,
    parameter int NWR    = 4,
    parameter int NRD    = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    commitAllow,
    input  logic [NWR-1:0]          writeEn,
    input  logic [NWR*IDX_W-1:0]    writeSelect,
    input  logic [NWR*DESC_W-1:0]   writeData,
    input  logic [NRD*IDX_W-1:0]    readSelect,
    output logic [NRD*DESC_W-1:0]   readData,
    input  logic                    clearReq,
    output logic                    clearBusy,
    output logic                    writeConflict
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               conflict_q, conflict_d;
    logic [DESC_W-1:0]  entry_q [NREGS];
    logic [DESC_W-1:0]  entry_d [NREGS];
    logic [NWR-1:0]     accept;

    // clearBusy comes straight from the state register, so it is glitch-free
    assign clearBusy     = (state_q == CLEAR);
    assign writeConflict = conflict_q;

    // Write acceptance. The reset term keeps the bypass path quiet while the
    // table is held in reset, so readData reads all zero during reset.
    always_comb begin
        accept = '0;
        for (int k = 0; k < NWR; k++) begin
            accept[k] = reset & en & commitAllow & writeEn[k] & (state_q == IDLE);
        end
    end

    // Flag any pair of accepted writes that target the same index
    always_comb begin
        conflict_d = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            for (int j = i + 1; j < NWR; j++) begin
                if (accept[i] && accept[j] &&
                    (writeSelect[i*IDX_W +: IDX_W] == writeSelect[j*IDX_W +: IDX_W])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Clear-sweep FSM. clearReq is ignored during the sweep. The pointer
    // wraps back to zero on the last group, so no extra reset of it is needed.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clearReq) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + IDX_W'(NWR);
                if (ptr_q == IDX_W'(NREGS - NWR)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Next table contents. Ports are applied in ascending order, so the
    // highest-numbered accepted port wins a collision. Writes and the sweep
    // never overlap, because accept is forced low while in CLEAR.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            entry_d[r] = entry_q[r];
        end
        for (int k = 0; k < NWR; k++) begin
            if (accept[k]) begin
                entry_d[writeSelect[k*IDX_W +: IDX_W]] = writeData[k*DESC_W +: DESC_W];
            end
        end
        if (state_q == CLEAR) begin
            for (int g = 0; g < NWR; g++) begin
                entry_d[ptr_q + IDX_W'(g)] = '0;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            conflict_q <= 1'b0;
            for (int r = 0; r < NREGS; r++) begin
                entry_q[r] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            conflict_q <= conflict_d;
            for (int r = 0; r < NREGS; r++) begin
                entry_q[r] <= entry_d[r];
            end
        end
    end

    // Zero-latency read ports, with optional same-cycle write bypass
    always_comb begin
        readData = '0;
        for (int j = 0; j < NRD; j++) begin
            readData[j*DESC_W +: DESC_W] = entry_q[readSelect[j*IDX_W +: IDX_W]];
`ifdef PHYS_REG_DESC_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (accept[k] &&
                    (writeSelect[k*IDX_W +: IDX_W] == readSelect[j*IDX_W +: IDX_W])) begin
                    readData[j*DESC_W +: DESC_W] = writeData[k*DESC_W +: DESC_W];
                end
            end
`else
`endif
        end
    end

endmodule

// File: doc/phys_reg_desc_table.md
PHYS_REG_DESC_TABLE -- requirements
Module: phys_reg_desc_table

Interface
REQ-001 SHALL have parameter NREGS, default 64, number of physical-register descriptor entries (power of two, multiple of NWR).
REQ-002 SHALL have parameter IDX_W, default 6, index width (log2 NREGS).
REQ-003 SHALL have parameter DESC_W, default 3, descriptor width per entry.
REQ-004 SHALL have parameter NWR, default 4, number of write ports.
REQ-005 SHALL have parameter NRD, default 12, number of read ports.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port en  input  1  global write enable.
REQ-009 SHALL have port commitAllow  input  1  write qualifier from commit stage.
REQ-010 SHALL have port writeEn  input  NWR  per-port write enable, bit k = port k.
REQ-011 SHALL have port writeSelect  input  NWR*IDX_W  packed write indices, port k at [k*IDX_W +: IDX_W].
REQ-012 SHALL have port writeData  input  NWR*DESC_W  packed write descriptors, port k at [k*DESC_W +: DESC_W].
REQ-013 SHALL have port readSelect  input  NRD*IDX_W  packed read indices.
REQ-014 SHALL have port readData  output  NRD*DESC_W  packed read descriptors.
REQ-015 SHALL have port clearReq  input  1  request to zero whole table.
REQ-016 SHALL have port clearBusy  output  1  high while clear sweep in progress.
REQ-017 SHALL have port writeConflict  output  1  registered pulse: previous cycle had two accepted writes to one index.

Function
REQ-018 Write port k SHALL be accepted when en & commitAllow & writeEn[k] & !clearBusy; entry updated at next rising edge.
REQ-019 Same-cycle accepted writes to one index: highest-numbered port SHALL win; lower ports discarded.
REQ-020 writeConflict SHALL be 1 in the cycle after any REQ-019 collision, else 0.
REQ-021 readData port j SHALL combinationally equal entry[readSelect j] (zero latency), subject to REQ-027.
REQ-022 State machine SHALL have states IDLE and CLEAR; reset state IDLE.
REQ-023 IDLE with clearReq=1 SHALL go to CLEAR next edge, sweep pointer=0, clearBusy=1 (registered); clearReq is level-sampled, en not required.
REQ-024 In CLEAR each cycle SHALL zero entries pointer..pointer+NWR-1 and advance pointer by NWR; sweep takes NREGS/NWR cycles.
REQ-025 When last group is zeroed, SHALL return to IDLE next edge, clearBusy=0; clearReq during CLEAR ignored (no restart); clearReq still high on return starts a new sweep.
REQ-026 Writes SHALL be blocked while clearBusy=1; writes in the IDLE->CLEAR transition cycle are accepted and later overwritten by the sweep.

Reset
REQ-027 reset=0 SHALL asynchronously zero all entries, state=IDLE, pointer=0, clearBusy=0, writeConflict=0; readData therefore 0 on all ports.
REQ-028 reset asserted mid-sweep SHALL abort sweep; after release block is IDLE with all entries zero.

Configuration
REQ-029 With PHYS_REG_DESC_BYPASS_EN defined, readData port j SHALL return writeData of the winning accepted write whose index equals readSelect j in the same cycle, else stored entry.
REQ-030 Without PHYS_REG_DESC_BYPASS_EN, readData SHALL return only stored entries (new value visible cycle after write).

Verification
REQ-031 Reset release, read all 64 indices -> every readData = 0, clearBusy=0, writeConflict=0.
REQ-032 en=1, commitAllow=1, port0 writes idx 5 = 3'b101, port3 writes idx 5 = 3'b010 -> next cycle idx 5 reads 3'b010, writeConflict=1 for one cycle.
REQ-033 commitAllow=0, writeEn=4'b1111 to idx 1..4 = 3'b111 -> entries remain 0.
REQ-034 Fill idx 0..63 = 3'b110, pulse clearReq -> clearBusy high exactly 16 cycles; writes during sweep ignored; all entries 0 after.
REQ-035 Bypass build: write idx 9 = 3'b011 while readSelect0=9 -> readData0=3'b011 same cycle; non-bypass build -> 0 same cycle, 3'b011 next cycle.
REQ-036 reset=0 asserted at sweep cycle 7 with stale data in idx 60 -> immediately idx 60 reads 0, clearBusy=0; after release, clearReq low -> stays IDLE.
